alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Pipeline register stage directly upstream of the ALU. Latches decoded operands, then drives the
//  muxed A/B operands and func3/func7 into the ALU. Uses a valid/ready handshake.
//  A 2-entry skid buffer makes the upstream ready a pure register. Supports flush.
// PARAMETERS
//  XLEN      32  operand/PC/immediate width
//  REGADDR_W 5   register address width
// PORTS
//  iClk       in   1          clock; all state updates on rising edge
//  iRst_n     in   1          asynchronous, active-low reset
//  iFlush     in   1          discard all held and incoming entries
//  iValid     in   1          upstream entry valid
//  oReady     out  1          stage can accept (registered; == skid entry empty)
//  iPc        in   XLEN       instruction PC
//  iRs1Val    in   XLEN       rs1 register value
//  iRs2Val    in   XLEN       rs2 register value
//  iImm       in   XLEN       sign-extended immediate
//  iRs1Addr   in   REGADDR_W  rs1 index (forwarding match)
//  iRs2Addr   in   REGADDR_W  rs2 index (forwarding match)
//  iRdAddr    in   REGADDR_W  destination index, passed through
//  iSelA      in   1          0: A=rs1, 1: A=PC
//  iSelB      in   1          0: B=rs2, 1: B=imm
//  iFunc3     in   3          ALU func3, passed through
//  iFunc7     in   7          ALU func7, passed through
//  oValid     out  1          head entry valid toward ALU
//  iReady     in   1          ALU/downstream accepts head entry
//  oA, oB     out  XLEN       muxed operands for ALU iA/iB
//  oFunc3     out  3          head func3
//  oFunc7     out  7          head func7
//  oRdAddr    out  REGADDR_W  head destination index
//  iFwdValid  in   1          (ALU_ISSUE_FWD_EN only) writeback result valid
//  iFwdAddr   in   REGADDR_W  (ALU_ISSUE_FWD_EN only) writeback destination
//  iFwdData   in   XLEN       (ALU_ISSUE_FWD_EN only) writeback data
// BEHAVIOUR
//  - Reset (iRst_n=0, async): state EMPTY; oValid=0; oReady=1; all entry fields and oA/oB/oFunc*/oRdAddr=0.
//  - Transfers: in_xfer = iValid & oReady; out_xfer = oValid & iReady.
//  - Latency is 1 cycle: an entry accepted in cycle N is on the outputs in N+1. Throughput is 1/cycle.
//  - Storage is a head entry plus a skid entry. Each stores pc, rs1, rs2, imm, addrs, sel, func3/7, rd.
//  - oA/oB are a combinational mux of the head entry's fields. func/rd come straight from head.
//  - FSM: EMPTY, ONE (head full), TWO (head+skid full). oValid = (state != EMPTY).
//  - oReady = (state != TWO), registered.
//    EMPTY: in_xfer -> head<=in, ONE.
//    ONE:   in_xfer & out_xfer -> head<=in, stay ONE; in_xfer only -> skid<=in, TWO;
//           out_xfer only -> EMPTY.
//    TWO:   no input is accepted. out_xfer -> head<=skid, ONE.
//  - Held entries never change while iReady=0, except for forwarding updates.
//  - iFlush has priority over everything. Next state is EMPTY and oReady=1.
//    An input presented in the flush cycle is dropped. An out_xfer in the flush cycle still counts downstream.
//  - X-safety: entries are written only on accept. Invalid slots keep stale data, which is don't-care.
// CONFIGURATION
//  - Macro ALU_ISSUE_FWD_EN defined: the iFwd* ports exist. Every cycle with iFwdValid and iFwdAddr!=0:
//    - Any held entry whose rs1Addr (rs2Addr) == iFwdAddr has its rs1 (rs2) overwritten with iFwdData.
//    - An entry being captured that cycle takes iFwdData instead of iRs1Val/iRs2Val on a match.
//    - Address x0 is never forwarded.
//  - Not defined: the iFwd* ports are absent. Operands are exactly the captured values.
// STRUCTURE
//  - Package alu_issue_pkg:
//    - typedef issue_entry_t (packed struct of all stored fields).
//    - enum issue_state_t {EMPTY, ONE, TWO}.
//    - localparams SEL_A_RS1/SEL_A_PC, SEL_B_RS2/SEL_B_IMM.
//  - Sub-module alu_issue_entry: one entry register with load enable, load data, and forward-match
//    update logic. Instantiated twice (head, skid). The FSM and output mux live in the top.
// TESTING
//  1. Reset mid-stream -> all outputs 0 immediately. After release: oValid=0, oReady=1.
//  2. rs1=5, imm=7, SelA=0, SelB=1, iReady=1 -> next cycle oValid=1, oA=5, oB=7.
//     Back-to-back stream of 10 entries -> 10 outputs in order, no bubbles.
//  3. iReady=0 with 2 entries sent -> state TWO, oReady=0. The 3rd entry is not taken.
//     iReady=1 -> outputs in order, oReady returns to 1 one cycle after the first drain.
//  4. Flush with TWO held and iValid=1 -> next cycle oValid=0, oReady=1. The flush-cycle input is never output.
//  5. SelA=1, PC=0x100, SelB=0, rs2=0xFFFFFFFF -> oA=0x100, oB=0xFFFFFFFF.
//     func3=3'b101 and func7=7'h20 pass through unchanged.
//  6. FWD_EN, held entry rs1Addr=3, iFwd(3,0xDEAD) -> oA=0xDEAD.
//     iFwd(0,0xBEEF) with rs2Addr=0 -> oB unchanged.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Forwarding helper is only compiled when ALU_ISSUE_FWD_EN is defined.
package alu_issue_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REGADDR_W = 5;

   localparam logic SEL_A_RS1 = 1'b0;
   localparam logic SEL_A_PC  = 1'b1;
   localparam logic SEL_B_RS2 = 1'b0;
   localparam logic SEL_B_IMM = 1'b1;

   typedef struct packed {
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      rs1;
      logic [XLEN-1:0]      rs2;
      logic [XLEN-1:0]      imm;
      logic [REGADDR_W-1:0] rs1_addr;
      logic [REGADDR_W-1:0] rs2_addr;
      logic [REGADDR_W-1:0] rd_addr;
      logic                 sel_a;
      logic                 sel_b;
      logic [2:0]           func3;
      logic [6:0]           func7;
   } issue_entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } issue_state_t;

`ifdef ALU_ISSUE_FWD_EN
   // Replace source operands whose address matches a writeback; x0 never forwards.
   function automatic issue_entry_t fwd_apply(input issue_entry_t e,
                                              input logic fwd_valid,
                                              input logic [REGADDR_W-1:0] fwd_addr,
                                              input logic [XLEN-1:0] fwd_data);
      issue_entry_t r;
      r = e;
      if (fwd_valid && (fwd_addr != '0)) begin
         if (e.rs1_addr == fwd_addr) r.rs1 = fwd_data;
         if (e.rs2_addr == fwd_addr) r.rs2 = fwd_data;
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/alu_issue_entry.sv
// One issue-stage entry register with load enable and writeback-forward update.
// Forward ports exist only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_entry
   import alu_issue_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 load_i,
   input  issue_entry_t         data_i,
`ifdef ALU_ISSUE_FWD_EN
   input  logic                 fwd_valid_i,
   input  logic [REGADDR_W-1:0] fwd_addr_i,
   input  logic [XLEN-1:0]      fwd_data_i,
`endif
   output issue_entry_t         entry_o
);

   issue_entry_t entry_q;
   issue_entry_t entry_d;

   // Forwarding applies both to the held value and to the value being loaded.
   always_comb begin
`ifdef ALU_ISSUE_FWD_EN
      entry_d = fwd_apply(load_i ? data_i : entry_q, fwd_valid_i, fwd_addr_i, fwd_data_i);
`else
      entry_d = load_i ? data_i : entry_q;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) entry_q <= '0;
      else         entry_q <= entry_d;
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Pipeline stage ahead of the ALU: head + skid entry, registered upstream ready, flush.
// Define ALU_ISSUE_FWD_EN to enable writeback forwarding into held/captured operands.
module alu_issue_stage
   import alu_issue_pkg::*;
(
   input  logic                 iClk,
   input  logic                 iRst_n,
   input  logic                 iFlush,
   input  logic                 iValid,
   output logic                 oReady,
   input  logic [XLEN-1:0]      iPc,
   input  logic [XLEN-1:0]      iRs1Val,
   input  logic [XLEN-1:0]      iRs2Val,
   input  logic [XLEN-1:0]      iImm,
   input  logic [REGADDR_W-1:0] iRs1Addr,
   input  logic [REGADDR_W-1:0] iRs2Addr,
   input  logic [REGADDR_W-1:0] iRdAddr,
   input  logic                 iSelA,
   input  logic                 iSelB,
   input  logic [2:0]           iFunc3,
   input  logic [6:0]           iFunc7,
`ifdef ALU_ISSUE_FWD_EN
   input  logic                 iFwdValid,
   input  logic [REGADDR_W-1:0] iFwdAddr,
   input  logic [XLEN-1:0]      iFwdData,
`endif
   output logic                 oValid,
   input  logic                 iReady,
   output logic [XLEN-1:0]      oA,
   output logic [XLEN-1:0]      oB,
   output logic [2:0]           oFunc3,
   output logic [6:0]           oFunc7,
   output logic [REGADDR_W-1:0] oRdAddr
);

   issue_state_t state_q, state_d;
   logic         ready_q, ready_d;
   logic         head_load, head_from_skid, skid_load;
   logic         in_xfer, out_xfer;
   issue_entry_t in_entry, head_data, head_entry, skid_entry;

   assign in_entry = '{pc: iPc, rs1: iRs1Val, rs2: iRs2Val, imm: iImm,
                       rs1_addr: iRs1Addr, rs2_addr: iRs2Addr, rd_addr: iRdAddr,
                       sel_a: iSelA, sel_b: iSelB, func3: iFunc3, func7: iFunc7};

   assign oValid   = (state_q != EMPTY);
   assign oReady   = ready_q;
   assign in_xfer  = iValid & ready_q;
   assign out_xfer = oValid & iReady;

   // Next-state and entry load control; flush overrides every transition.
   always_comb begin
      state_d        = state_q;
      head_load      = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (iFlush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (in_xfer) begin
               head_load = 1'b1;
               state_d   = ONE;
            end
            ONE: if (in_xfer && out_xfer) begin
               head_load = 1'b1;
            end else if (in_xfer) begin
               skid_load = 1'b1;
               state_d   = TWO;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
            TWO: if (out_xfer) begin
               head_load      = 1'b1;
               head_from_skid = 1'b1;
               state_d        = ONE;
            end
            default: state_d = EMPTY;
         endcase
      end
      ready_d = (state_d != TWO);
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
      end
   end

   assign head_data = head_from_skid ? skid_entry : in_entry;

   alu_issue_entry u_head (
      .clk_i       (iClk),
      .rst_ni      (iRst_n),
      .load_i      (head_load),
      .data_i      (head_data),
`ifdef ALU_ISSUE_FWD_EN
      .fwd_valid_i (iFwdValid),
      .fwd_addr_i  (iFwdAddr),
      .fwd_data_i  (iFwdData),
`endif
      .entry_o     (head_entry)
   );

   alu_issue_entry u_skid (
      .clk_i       (iClk),
      .rst_ni      (iRst_n),
      .load_i      (skid_load),
      .data_i      (in_entry),
`ifdef ALU_ISSUE_FWD_EN
      .fwd_valid_i (iFwdValid),
      .fwd_addr_i  (iFwdAddr),
      .fwd_data_i  (iFwdData),
`endif
      .entry_o     (skid_entry)
   );

   assign oA      = (head_entry.sel_a == SEL_A_PC)  ? head_entry.pc  : head_entry.rs1;
   assign oB      = (head_entry.sel_b == SEL_B_IMM) ? head_entry.imm : head_entry.rs2;
   assign oFunc3  = head_entry.func3;
   assign oFunc7  = head_entry.func7;
   assign oRdAddr = head_entry.rd_addr;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage against a queue-based transaction model.
module tb_alu_issue_stage;

   logic        iClk = 1'b0;
   logic        iRst_n, iFlush, iValid, oReady, iReady, oValid;
   logic [31:0] iPc, iRs1Val, iRs2Val, iImm, oA, oB;
   logic [4:0]  iRs1Addr, iRs2Addr, iRdAddr, oRdAddr;
   logic        iSelA, iSelB;
   logic [2:0]  iFunc3, oFunc3;
   logic [6:0]  iFunc7, oFunc7;
   logic        iFwdValid;
   logic [4:0]  iFwdAddr;
   logic [31:0] iFwdData;

   typedef struct {
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  r1, r2, rd;
      logic        sa, sb;
      logic [2:0]  f3;
      logic [6:0]  f7;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 iClk = ~iClk;

   alu_issue_stage dut (
      .iClk(iClk), .iRst_n(iRst_n), .iFlush(iFlush), .iValid(iValid), .oReady(oReady),
      .iPc(iPc), .iRs1Val(iRs1Val), .iRs2Val(iRs2Val), .iImm(iImm),
      .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .iRdAddr(iRdAddr),
      .iSelA(iSelA), .iSelB(iSelB), .iFunc3(iFunc3), .iFunc7(iFunc7),
`ifdef ALU_ISSUE_FWD_EN
      .iFwdValid(iFwdValid), .iFwdAddr(iFwdAddr), .iFwdData(iFwdData),
`endif
      .oValid(oValid), .iReady(iReady), .oA(oA), .oB(oB),
      .oFunc3(oFunc3), .oFunc7(oFunc7), .oRdAddr(oRdAddr)
   );

   function automatic ent_t rand_ent();
      ent_t e;
      e.pc = $urandom; e.rs1 = $urandom; e.rs2 = $urandom; e.imm = $urandom;
      e.r1 = 5'($urandom_range(0, 7)); e.r2 = 5'($urandom_range(0, 7));
      e.rd = 5'($urandom); e.sa = 1'($urandom); e.sb = 1'($urandom);
      e.f3 = 3'($urandom); e.f7 = 7'($urandom);
      return e;
   endfunction

   function automatic logic [31:0] ea(input ent_t e);
      return e.sa ? e.pc : e.rs1;
   endfunction

   function automatic logic [31:0] eb(input ent_t e);
      return e.sb ? e.imm : e.rs2;
   endfunction

   // One clock: drive at negedge, advance model, return at the next negedge.
   task automatic step(input logic v, input logic r, input logic fl, input ent_t e,
                       input logic fv = 1'b0, input logic [4:0] fa = 5'd0,
                       input logic [31:0] fd = 32'd0);
      bit   mready, mvalid;
      ent_t ne;
      mready = (q.size() < 2);
      mvalid = (q.size() > 0);
      iValid = v; iReady = r; iFlush = fl;
      iPc = e.pc; iRs1Val = e.rs1; iRs2Val = e.rs2; iImm = e.imm;
      iRs1Addr = e.r1; iRs2Addr = e.r2; iRdAddr = e.rd;
      iSelA = e.sa; iSelB = e.sb; iFunc3 = e.f3; iFunc7 = e.f7;
      iFwdValid = fv; iFwdAddr = fa; iFwdData = fd;
      if (mvalid && r) void'(q.pop_front());
      if (fl) begin
         q.delete();
      end else begin
         ne = e;
`ifdef ALU_ISSUE_FWD_EN
         if (fv && fa != 5'd0) begin
            foreach (q[i]) begin
               if (q[i].r1 == fa) q[i].rs1 = fd;
               if (q[i].r2 == fa) q[i].rs2 = fd;
            end
            if (ne.r1 == fa) ne.rs1 = fd;
            if (ne.r2 == fa) ne.rs2 = fd;
         end
`endif
         if (v && mready) q.push_back(ne);
      end
      @(posedge iClk);
      @(negedge iClk);
   endtask

   task automatic idle(input logic r);
      ent_t z;
      z = rand_ent();
      step(1'b0, r, 1'b0, z);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 1'b0, rand_ent());
      step(1'b1, 1'b0, 1'b0, rand_ent());
      iRst_n = 1'b0;
      #1;
      q.delete();
      checks++;
      if ({oValid, oA, oB, oFunc3, oFunc7, oRdAddr} !== '0) begin
         failures++;
         $display("FAIL reset_outs: got v=%0b a=%h b=%h f3=%h f7=%h rd=%h want all 0",
                  oValid, oA, oB, oFunc3, oFunc7, oRdAddr);
      end
      checks++;
      if (oReady !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b want 1", oReady);
      end
      @(negedge iClk);
      iRst_n = 1'b1;
      idle(1'b0);
      checks++;
      if (oValid !== 1'b0 || oReady !== 1'b1) begin
         failures++;
         $display("FAIL post_reset: got v=%b rdy=%b want v=0 rdy=1", oValid, oReady);
      end
   endtask

   task automatic test_basic();
      ent_t e;
      e = rand_ent();
      e.rs1 = 32'd5; e.imm = 32'd7; e.sa = 1'b0; e.sb = 1'b1;
      step(1'b1, 1'b1, 1'b0, e);
      checks++;
      if (oValid !== 1'b1 || oA !== 32'd5 || oB !== 32'd7) begin
         failures++;
         $display("FAIL basic: got v=%b a=%0d b=%0d want v=1 a=5 b=7", oValid, oA, oB);
      end
      idle(1'b1);
      checks++;
      if (oValid !== 1'b0) begin
         failures++;
         $display("FAIL basic_drain: got v=%b want 0", oValid);
      end
   endtask

   task automatic test_back_to_back();
      ent_t sent[10];
      foreach (sent[i]) sent[i] = rand_ent();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 1'b0, sent[i]);
         checks++;
         if (oValid !== 1'b1 || oReady !== 1'b1 || oA !== ea(sent[i]) || oB !== eb(sent[i]) ||
             oRdAddr !== sent[i].rd) begin
            failures++;
            $display("FAIL stream[%0d]: got v=%b rdy=%b a=%h b=%h rd=%0d want v=1 rdy=1 a=%h b=%h rd=%0d",
                     i, oValid, oReady, oA, oB, oRdAddr, ea(sent[i]), eb(sent[i]), sent[i].rd);
         end
      end
      idle(1'b1);
      checks++;
      if (oValid !== 1'b0) begin
         failures++;
         $display("FAIL stream_end: got v=%b want 0", oValid);
      end
   endtask

   task automatic test_backpressure();
      ent_t e0, e1, e2;
      e0 = rand_ent(); e1 = rand_ent(); e2 = rand_ent();
      step(1'b1, 1'b0, 1'b0, e0);
      step(1'b1, 1'b0, 1'b0, e1);
      checks++;
      if (oReady !== 1'b0 || oValid !== 1'b1 || oA !== ea(e0)) begin
         failures++;
         $display("FAIL bp_two: got rdy=%b v=%b a=%h want rdy=0 v=1 a=%h", oReady, oValid, oA, ea(e0));
      end
      step(1'b1, 1'b0, 1'b0, e2);
      checks++;
      if (oReady !== 1'b0 || oA !== ea(e0) || oB !== eb(e0)) begin
         failures++;
         $display("FAIL bp_hold: got rdy=%b a=%h b=%h want rdy=0 a=%h b=%h",
                  oReady, oA, oB, ea(e0), eb(e0));
      end
      idle(1'b1);
      checks++;
      if (oReady !== 1'b1 || oValid !== 1'b1 || oA !== ea(e1) || oB !== eb(e1)) begin
         failures++;
         $display("FAIL bp_drain1: got rdy=%b v=%b a=%h b=%h want rdy=1 v=1 a=%h b=%h",
                  oReady, oValid, oA, oB, ea(e1), eb(e1));
      end
      idle(1'b1);
      checks++;
      if (oValid !== 1'b0) begin
         failures++;
         $display("FAIL bp_drain2: got v=%b want 0 (third entry must be dropped)", oValid);
      end
   endtask

   task automatic test_flush();
      step(1'b1, 1'b0, 1'b0, rand_ent());
      step(1'b1, 1'b0, 1'b0, rand_ent());
      step(1'b1, 1'b0, 1'b1, rand_ent());
      checks++;
      if (oValid !== 1'b0 || oReady !== 1'b1) begin
         failures++;
         $display("FAIL flush: got v=%b rdy=%b want v=0 rdy=1", oValid, oReady);
      end
      idle(1'b1);
      checks++;
      if (oValid !== 1'b0) begin
         failures++;
         $display("FAIL flush_input: got v=%b want 0", oValid);
      end
   endtask

   task automatic test_mux();
      ent_t e;
      e = rand_ent();
      e.sa = 1'b1; e.pc = 32'h100; e.sb = 1'b0; e.rs2 = 32'hFFFF_FFFF;
      e.f3 = 3'b101; e.f7 = 7'h20; e.rd = 5'd17;
      step(1'b1, 1'b1, 1'b0, e);
      checks++;
      if (oA !== 32'h100 || oB !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL mux: got a=%h b=%h want a=00000100 b=ffffffff", oA, oB);
      end
      checks++;
      if (oFunc3 !== 3'b101 || oFunc7 !== 7'h20 || oRdAddr !== 5'd17) begin
         failures++;
         $display("FAIL func: got f3=%b f7=%h rd=%0d want f3=101 f7=20 rd=17", oFunc3, oFunc7, oRdAddr);
      end
      idle(1'b1);
   endtask

`ifdef ALU_ISSUE_FWD_EN
   task automatic test_fwd();
      ent_t e;
      e = rand_ent();
      e.r1 = 5'd3; e.r2 = 5'd0; e.sa = 1'b0; e.sb = 1'b0; e.rs1 = 32'h1111; e.rs2 = 32'h2222;
      step(1'b1, 1'b0, 1'b0, e);
      step(1'b0, 1'b0, 1'b0, e, 1'b1, 5'd3, 32'hDEAD);
      checks++;
      if (oA !== 32'hDEAD) begin
         failures++;
         $display("FAIL fwd_rs1: got a=%h want 0000dead", oA);
      end
      step(1'b0, 1'b0, 1'b0, e, 1'b1, 5'd0, 32'hBEEF);
      checks++;
      if (oB !== 32'h2222) begin
         failures++;
         $display("FAIL fwd_x0: got b=%h want 00002222", oB);
      end
      idle(1'b1);
   endtask
`endif

   task automatic test_random();
      ent_t        h;
      logic        fv;
      logic [4:0]  fa;
      for (int n = 0; n < 400; n++) begin
         fv = 1'($urandom_range(0, 3) == 0);
         fa = 5'($urandom_range(0, 7));
         step(1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
              rand_ent(), fv, fa, $urandom);
         checks++;
         if (q.size() == 0) begin
            if (oValid !== 1'b0 || oReady !== 1'b1) begin
               failures++;
               $display("FAIL rand_empty[%0d]: got v=%b rdy=%b want v=0 rdy=1", n, oValid, oReady);
            end
         end else begin
            h = q[0];
            if ({oValid, oReady, oA, oB, oFunc3, oFunc7, oRdAddr} !==
                {1'b1, (q.size() < 2), ea(h), eb(h), h.f3, h.f7, h.rd}) begin
               failures++;
               $display("FAIL rand[%0d]: got v=%b rdy=%b a=%h b=%h f3=%h f7=%h rd=%0d want v=1 rdy=%b a=%h b=%h f3=%h f7=%h rd=%0d",
                        n, oValid, oReady, oA, oB, oFunc3, oFunc7, oRdAddr,
                        (q.size() < 2), ea(h), eb(h), h.f3, h.f7, h.rd);
            end
         end
      end
   endtask

   initial begin
      iRst_n = 1'b0; iFlush = 1'b0; iValid = 1'b0; iReady = 1'b0;
      iPc = '0; iRs1Val = '0; iRs2Val = '0; iImm = '0;
      iRs1Addr = '0; iRs2Addr = '0; iRdAddr = '0; iSelA = 1'b0; iSelB = 1'b0;
      iFunc3 = '0; iFunc7 = '0; iFwdValid = 1'b0; iFwdAddr = '0; iFwdData = '0;
      repeat (2) @(negedge iClk);
      iRst_n = 1'b1;
      @(negedge iClk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_mux();
`ifdef ALU_ISSUE_FWD_EN
      test_fwd();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
